// File: rtl/bp_mem_responder_lite_pkg.sv
// Shared memory-message types, encodings and configuration helpers for the
// lightweight CCE memory responder.
package bp_mem_responder_lite_pkg;

  typedef enum logic [0:0] {e_bp_inv_cfg = 1'b0} bp_params_e;

  localparam int paddr_width_gp      = 40;
  localparam int cce_block_width_gp  = 512;
  localparam int lce_id_width_gp     = 4;
  localparam int way_id_width_gp     = 4;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic [way_id_width_gp-1:0] way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    logic [3:0]                msg_type;
    logic [paddr_width_gp-1:0] addr;
    logic [2:0]                size;
    bp_cce_mem_payload_s       payload;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    bp_cce_mem_msg_header_s        header;
    logic [cce_block_width_gp-1:0] data;
  } bp_cce_mem_msg_s;

  function automatic int bp_cce_block_width(bp_params_e cfg);
    case (cfg)
      e_bp_inv_cfg: return cce_block_width_gp;
      default:      return cce_block_width_gp;
    endcase
  endfunction

  function automatic int bp_cce_mem_msg_width(bp_params_e cfg);
    case (cfg)
      e_bp_inv_cfg: return $bits(bp_cce_mem_msg_s);
      default:      return $bits(bp_cce_mem_msg_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_mem_responder_storage.sv
// Single-port synchronous block RAM with per-byte write mask; contents are
// intentionally never reset. Read data holds until the next read.
module bp_mem_responder_storage #(
  parameter  int els_p         = 1024,
  parameter  int width_p       = 512,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (mask_i[b]) mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
    if (v_i && !w_i) data_o <= mem_r[addr_i];
  end

endmodule

// File: rtl/bp_mem_responder_lite.sv
// Single-outstanding CCE memory responder: accepts one command, waits a
// fixed latency, then presents the echoed header with read or zero data.
module bp_mem_responder_lite
  import bp_mem_responder_lite_pkg::*;
#(
  parameter  bp_params_e bp_params_p      = e_bp_inv_cfg,
  parameter  int         mem_els_p        = 1024,
  parameter  int         latency_p        = 4,
  localparam int         cce_block_width_p    = bp_cce_block_width(bp_params_p),
  localparam int         cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);

  // state   | meaning
  // READY   | idle, mem_cmd_ready_o high, waiting for a command
  // WAIT    | command latched, counting down the response latency
  // RESP    | response valid, held until the consumer yumis it
  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  localparam int block_bytes_lp  = cce_block_width_p / 8;
  localparam int offset_width_lp = $clog2(block_bytes_lp);
  localparam int index_width_lp  = $clog2(mem_els_p);

  bp_cce_mem_msg_s        cmd;
  bp_cce_mem_msg_header_s hdr_r;
  state_e                 state_r;
  logic [7:0]             cnt_r;
  logic                   ready_r, resp_v_r, accept;

  logic                           ram_v, ram_w;
  logic [cce_block_width_p-1:0]   ram_wdata, ram_rdata, rd_shift, resp_data;
  logic [block_bytes_lp-1:0]      ram_mask;
  logic [offset_width_lp:0]       wr_nb, rd_nb;
  logic [offset_width_lp-1:0]     wr_base, rd_base;

  // Oversized encodings clamp to a whole block.
  function automatic logic [offset_width_lp:0] size_bytes(input logic [2:0] size);
    if (32'(size) >= offset_width_lp) return (offset_width_lp+1)'(block_bytes_lp);
    return (offset_width_lp+1)'(1) << size;
  endfunction

  function automatic logic [offset_width_lp-1:0] size_base(
    input logic [offset_width_lp-1:0] off, input logic [offset_width_lp:0] nb);
    return off & ~(nb[offset_width_lp-1:0] - 1'b1);
  endfunction

  assign cmd    = mem_cmd_i;
  assign accept = mem_cmd_v_i && ready_r;

  assign wr_nb   = size_bytes(cmd.header.size);
  assign wr_base = size_base(cmd.header.addr[offset_width_lp-1:0], wr_nb);
  assign rd_nb   = size_bytes(hdr_r.size);
  assign rd_base = size_base(hdr_r.addr[offset_width_lp-1:0], rd_nb);

  assign ram_w = (cmd.header.msg_type == e_cce_mem_wr) || (cmd.header.msg_type == e_cce_mem_uc_wr);
  assign ram_v = accept && (ram_w || (cmd.header.msg_type == e_cce_mem_rd)
                                  || (cmd.header.msg_type == e_cce_mem_uc_rd));

  always_comb begin
    ram_mask  = '0;
    ram_wdata = cmd.data;
    if (cmd.header.msg_type == e_cce_mem_wr) begin
      ram_mask = '1;
    end else if (cmd.header.msg_type == e_cce_mem_uc_wr) begin
      ram_wdata = cmd.data << {wr_base, 3'b000};
      for (int b = 0; b < block_bytes_lp; b++)
        ram_mask[b] = (b >= int'(wr_base)) && (b < int'(wr_base) + int'(wr_nb));
    end
  end

  // The RAM is only touched on accept, so its read register stays stable
  // for the whole WAIT/RESP interval of the one outstanding command.
  always_comb begin
    rd_shift  = ram_rdata >> {rd_base, 3'b000};
    resp_data = '0;
    if (hdr_r.msg_type == e_cce_mem_rd) begin
      resp_data = ram_rdata;
    end else if (hdr_r.msg_type == e_cce_mem_uc_rd) begin
      for (int b = 0; b < block_bytes_lp; b++)
        if (b < int'(rd_nb)) resp_data[8*b +: 8] = rd_shift[8*b +: 8];
    end
  end

  bp_mem_responder_storage #(
    .els_p   (mem_els_p),
    .width_p (cce_block_width_p)
  ) storage (
    .clk_i  (clk_i),
    .v_i    (ram_v),
    .w_i    (ram_w),
    .addr_i (cmd.header.addr[offset_width_lp +: index_width_lp]),
    .data_i (ram_wdata),
    .mask_i (ram_mask),
    .data_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_ready;
      cnt_r    <= '0;
      hdr_r    <= '0;
      ready_r  <= 1'b0;
      resp_v_r <= 1'b0;
    end else begin
      case (state_r)
        e_ready: begin
          if (accept) begin
            hdr_r   <= cmd.header;
            ready_r <= 1'b0;
            if (latency_p == 0) begin
              state_r  <= e_resp;
              resp_v_r <= 1'b1;
            end else begin
              state_r <= e_wait;
              cnt_r   <= 8'(latency_p - 1);
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        e_wait: begin
          if (cnt_r == '0) begin
            state_r  <= e_resp;
            resp_v_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        e_resp: begin
          if (mem_resp_yumi_i) begin
            state_r  <= e_ready;
            resp_v_r <= 1'b0;
            ready_r  <= 1'b1;
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  assign mem_cmd_ready_o = ready_r;
  assign mem_resp_v_o    = resp_v_r;
  assign mem_resp_o      = resp_v_r ? {hdr_r, resp_data} : '0;

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      yumi_only_when_valid: assert (!(mem_resp_yumi_i && !mem_resp_v_o));
    end
  end

endmodule

// File: tb/tb_bp_mem_responder_lite.sv
// Scoreboarded bench: latency_p=4 instance for directed/random traffic and
// a latency_p=0 instance for back-to-back throughput.
module tb_bp_mem_responder_lite;
  import bp_mem_responder_lite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  bp_cce_mem_msg_s cmd_a, resp_a, cmd_b, resp_b;
  logic            cmd_v_a, ready_a, resp_v_a, yumi_a;
  logic            cmd_v_b, ready_b, resp_v_b, yumi_b;

  int n_vec  = 0;
  int n_miss = 0;

  bp_cce_mem_msg_s exp_q_a[$];
  bp_cce_mem_msg_s exp_q_b[$];
  logic [511:0]    model_a [1024];
  logic [511:0]    model_b [1024];
  logic [511:0]    pat0;

  bp_mem_responder_lite #(.mem_els_p(1024), .latency_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_i(cmd_a), .mem_cmd_v_i(cmd_v_a), .mem_cmd_ready_o(ready_a),
    .mem_resp_o(resp_a), .mem_resp_v_o(resp_v_a), .mem_resp_yumi_i(yumi_a));

  bp_mem_responder_lite #(.mem_els_p(1024), .latency_p(0)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_i(cmd_b), .mem_cmd_v_i(cmd_v_b), .mem_cmd_ready_o(ready_b),
    .mem_resp_o(resp_b), .mem_resp_v_o(resp_v_b), .mem_resp_yumi_i(yumi_b));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bp_cce_mem_msg_s mk(input logic [3:0] t, input logic [39:0] a,
                                         input logic [2:0] s, input logic [3:0] lce,
                                         input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m.header.msg_type       = t;
    m.header.addr           = a;
    m.header.size           = s;
    m.header.payload.lce_id = lce;
    m.header.payload.way_id = ~lce;
    m.data                  = d;
    return m;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Byte-addressed reference: uc ops touch nb bytes starting at the
  // size-aligned offset; data is taken from / returned in the low bytes.
  task automatic model_exec(input bit sel, input bp_cce_mem_msg_s c, output logic [511:0] d);
    logic [511:0] blk;
    logic [9:0]   idx;
    int nb, base;
    idx  = c.header.addr[15:6];
    blk  = sel ? model_b[idx] : model_a[idx];
    nb   = 1 << c.header.size;
    if (nb > 64) nb = 64;
    base = (int'(c.header.addr[5:0]) / nb) * nb;
    d    = '0;
    case (c.header.msg_type)
      e_cce_mem_rd:    d = blk;
      e_cce_mem_wr:    blk = c.data;
      e_cce_mem_uc_rd: for (int i = 0; i < nb; i++) d[8*i +: 8] = blk[8*(base+i) +: 8];
      e_cce_mem_uc_wr: for (int i = 0; i < nb; i++) blk[8*(base+i) +: 8] = c.data[8*i +: 8];
      default: ;
    endcase
    if (sel) model_b[idx] = blk;
    else     model_a[idx] = blk;
  endtask

  task automatic send_a(input bp_cce_mem_msg_s c, input int hold, output bp_cce_mem_msg_s got);
    logic [511:0]    d;
    bp_cce_mem_msg_s e;
    int              n;
    model_exec(1'b0, c, d);
    e = c;
    e.data = d;
    exp_q_a.push_back(e);
    @(negedge clk);
    cmd_a = c;
    cmd_v_a = 1'b1;
    n = 0;
    while (!ready_a && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_v_a = 1'b0;
    n = 1;
    while (!resp_v_a && n < 300) begin @(negedge clk); n++; end
    n_vec++;
    if (n !== 5) begin
      n_miss++;
      $display("FAIL latency: got %0d cycles, want 5", n);
    end
    e = exp_q_a.pop_front();
    for (int h = 0; h < hold; h++) begin
      n_vec++;
      if (resp_a !== e || resp_v_a !== 1'b1 || ready_a !== 1'b0) begin
        n_miss++;
        $display("FAIL hold[%0d]: got v=%b rdy=%b data=%h, want v=1 rdy=0 data=%h",
                 h, resp_v_a, ready_a, resp_a.data[63:0], e.data[63:0]);
      end
      cmd_a = mk(e_cce_mem_wr, 40'h0, e_mem_size_64, 4'hF, '1);
      cmd_v_a = 1'b1;
      @(negedge clk);
    end
    cmd_v_a = 1'b0;
    n_vec++;
    if (resp_a !== e) begin
      n_miss++;
      $display("FAIL resp_a: got hdr=%h data=%h, want hdr=%h data=%h",
               resp_a.header, resp_a.data, e.header, e.data);
    end
    got = resp_a;
    yumi_a = resp_v_a;
    @(negedge clk);
    yumi_a = 1'b0;
    n_vec++;
    if (resp_v_a !== 1'b0 || ready_a !== 1'b1) begin
      n_miss++;
      $display("FAIL release: got v=%b rdy=%b, want v=0 rdy=1", resp_v_a, ready_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_v_a = 1'b0; yumi_a = 1'b0; cmd_a = '0;
    cmd_v_b = 1'b0; yumi_b = 1'b0; cmd_b = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ready_a !== 1'b0 || resp_v_a !== 1'b0 || ready_b !== 1'b0 || resp_v_b !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_ctl: got rdy=%b%b v=%b%b, want 00 00", ready_a, ready_b, resp_v_a, resp_v_b);
    end
    n_vec++;
    if (resp_a !== '0 || resp_b !== '0) begin
      n_miss++;
      $display("FAIL reset_resp: got %h / %h, want 0", resp_a.header, resp_b.header);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_miss++;
      $display("FAIL ready_after_reset: got %b%b, want 11", ready_a, ready_b);
    end
  endtask

  task automatic test_uc_byte();
    bp_cce_mem_msg_s g;
    send_a(mk(e_cce_mem_wr, 40'h80_0000_0000, e_mem_size_64, 4'h1, '0), 0, g);
    send_a(mk(e_cce_mem_uc_wr, 40'h13, e_mem_size_1, 4'h2, 512'hAA), 0, g);
    send_a(mk(e_cce_mem_uc_rd, 40'h10, e_mem_size_8, 4'h3, '0), 0, g);
    n_vec++;
    if (g.data !== 512'h00000000_AA000000) begin
      n_miss++;
      $display("FAIL uc_byte: got %h, want 00000000aa000000", g.data[63:0]);
    end
  endtask

  task automatic test_uc_word();
    bp_cce_mem_msg_s g;
    send_a(mk(e_cce_mem_uc_wr, 40'h00_8000_0010, e_mem_size_8, 4'h4, 512'hDEADBEEF_CAFEF00D), 0, g);
    n_vec++;
    if (g.data !== '0) begin
      n_miss++;
      $display("FAIL uc_wr_data: got %h, want 0", g.data[63:0]);
    end
    send_a(mk(e_cce_mem_uc_rd, 40'h00_8000_0010, e_mem_size_8, 4'h5, '0), 0, g);
    n_vec++;
    if (g.data !== 512'hDEADBEEF_CAFEF00D) begin
      n_miss++;
      $display("FAIL uc_word: got %h, want deadbeefcafef00d", g.data[63:0]);
    end
  endtask

  task automatic test_hold();
    bp_cce_mem_msg_s g;
    send_a(mk(e_cce_mem_uc_rd, 40'h00_8000_0010, e_mem_size_8, 4'h6, '0), 10, g);
  endtask

  task automatic test_wrap();
    bp_cce_mem_msg_s g;
    pat0 = rand512();
    send_a(mk(e_cce_mem_wr, 40'h0, e_mem_size_64, 4'h7, pat0), 0, g);
    send_a(mk(e_cce_mem_rd, 40'h1_0000, e_mem_size_64, 4'h8, '0), 0, g);
    n_vec++;
    if (g.data !== pat0 || g.header.payload.lce_id !== 4'h8) begin
      n_miss++;
      $display("FAIL wrap: got lce=%h data=%h, want lce=8 data=%h", g.header.payload.lce_id, g.data, pat0);
    end
  endtask

  task automatic test_unsupported();
    bp_cce_mem_msg_s g;
    send_a(mk(e_cce_mem_pre, 40'h0, e_mem_size_64, 4'h9, '1), 0, g);
    send_a(mk(4'hF, 40'h0, e_mem_size_64, 4'hA, '1), 0, g);
    send_a(mk(e_cce_mem_rd, 40'h0, e_mem_size_64, 4'hB, '0), 0, g);
  endtask

  task automatic test_reset_mid();
    bp_cce_mem_msg_s g;
    int stray;
    @(negedge clk);
    cmd_a = mk(e_cce_mem_rd, 40'h40, e_mem_size_64, 4'hC, '0);
    cmd_v_a = 1'b1;
    for (int n = 0; n < 50 && !ready_a; n++) @(negedge clk);
    @(negedge clk);
    cmd_v_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_v_a) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_miss++;
      $display("FAIL reset_mid: got %0d stray valid cycles, want 0", stray);
    end
    send_a(mk(e_cce_mem_rd, 40'h0, e_mem_size_64, 4'hD, '0), 0, g);
    n_vec++;
    if (g.data !== pat0) begin
      n_miss++;
      $display("FAIL persist: got %h, want %h", g.data, pat0);
    end
  endtask

  task automatic test_random();
    bp_cce_mem_msg_s g;
    logic [39:0]     a;
    for (int blk = 1; blk <= 3; blk++)
      send_a(mk(e_cce_mem_wr, 40'(blk * 64), e_mem_size_64, 4'(blk), rand512()), 0, g);
    for (int k = 0; k < 10; k++) begin
      a[39:16] = 24'($urandom());
      a[15:6]  = 10'($urandom_range(1, 3));
      a[5:0]   = 6'($urandom_range(0, 63));
      send_a(mk(($urandom_range(0, 1) != 0) ? e_cce_mem_uc_wr : e_cce_mem_uc_rd, a,
                3'($urandom_range(0, 6)), 4'($urandom()), rand512()),
             $urandom_range(0, 2), g);
    end
  endtask

  task automatic test_back_to_back();
    bp_cce_mem_msg_s cmds[8];
    bp_cce_mem_msg_s e;
    logic [511:0]    d;
    int idx, got_n, last;
    cmds[0] = mk(e_cce_mem_wr,    40'h140,    e_mem_size_64, 4'h1, rand512());
    cmds[1] = mk(e_cce_mem_uc_wr, 40'h146,    e_mem_size_2,  4'h2, 512'h1234);
    cmds[2] = mk(e_cce_mem_uc_rd, 40'h145,    e_mem_size_4,  4'h3, '0);
    cmds[3] = mk(e_cce_mem_pre,   40'h140,    e_mem_size_64, 4'h4, '1);
    cmds[4] = mk(e_cce_mem_rd,    40'h140,    e_mem_size_64, 4'h5, '0);
    cmds[5] = mk(e_cce_mem_uc_rd, 40'h147,    e_mem_size_1,  4'h6, '0);
    cmds[6] = mk(e_cce_mem_uc_wr, 40'h5_0180, e_mem_size_64, 4'h7, rand512());
    cmds[7] = mk(e_cce_mem_uc_rd, 40'h1B8,    e_mem_size_8,  4'h8, '0);
    idx = 0; got_n = 0; last = -1;
    for (int cyc = 0; cyc < 60 && got_n < 8; cyc++) begin
      @(negedge clk);
      yumi_b = resp_v_b;
      if (resp_v_b) begin
        e = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : '0;
        n_vec++;
        if (resp_b !== e) begin
          n_miss++;
          $display("FAIL b2b[%0d]: got hdr=%h data=%h, want hdr=%h data=%h",
                   got_n, resp_b.header, resp_b.data, e.header, e.data);
        end
        if (last >= 0) begin
          n_vec++;
          if (cyc - last !== 2) begin
            n_miss++;
            $display("FAIL b2b_rate: got %0d cycles between responses, want 2", cyc - last);
          end
        end
        last = cyc;
        got_n++;
      end
      if (ready_b && idx < 8) begin
        model_exec(1'b1, cmds[idx], d);
        e = cmds[idx];
        e.data = d;
        exp_q_b.push_back(e);
        cmd_b = cmds[idx];
        cmd_v_b = 1'b1;
        idx++;
      end else begin
        cmd_v_b = 1'b0;
      end
    end
    @(negedge clk);
    yumi_b = 1'b0;
    cmd_v_b = 1'b0;
    n_vec++;
    if (got_n !== 8) begin
      n_miss++;
      $display("FAIL b2b_count: got %0d responses, want 8", got_n);
    end
  endtask

  initial begin
    test_reset();
    test_uc_byte();
    test_uc_word();
    test_hold();
    test_wrap();
    test_unsupported();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
